speed_limit_arbiter: RTL
========================

SPEED_LIMIT_ARBITER -- requirements
Module: speed_limit_arbiter

Interface
REQ-001 The block SHALL have parameter DEFAULT_LIMIT, default 8'd60, limit driven when no source is active.
REQ-002 The block SHALL have parameter RAMP_STEP, default 8'd2, maximum increase per ramp tick.
REQ-003 The block SHALL have parameter RAMP_DIV, default 8'd4, clock cycles per ramp tick (legal range 1..255).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 estop_req  input  1  level; emergency stop, forces limit 0.
REQ-008 sign_req  input  1  road-sign limit update strobe.
REQ-009 sign_limit  input  8  road-sign limit, km/h, sampled with sign_req.
REQ-010 sign_clear  input  1  invalidates the stored sign limit.
REQ-011 drv_req  input  1  driver setpoint update strobe.
REQ-012 drv_limit  input  8  driver setpoint, km/h; value 0 means "no driver limit".
REQ-013 sign_ack  output  1  sign update accepted.
REQ-014 drv_ack  output  1  driver update accepted.
REQ-015 speed_limit  output  8  arbitrated, rate-limited limit fed to the car control unit.
REQ-016 active_src  output  2  source of target: 00 default, 01 sign, 10 driver, 11 estop.
REQ-017 ramping  output  1  high while the FSM is in RAMP.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 On each edge with sign_req=1, sign_limit SHALL be stored and sign_valid set; sign_ack SHALL be 1 in the following cycle only.
REQ-020 sign_clear=1 without sign_req SHALL clear sign_valid; with sign_req and sign_clear both 1, the request SHALL win.
REQ-021 On each edge with drv_req=1, drv_limit SHALL be stored, drv_valid set iff drv_limit!=0; drv_ack SHALL be 1 in the following cycle only.
REQ-022 A held request SHALL capture every cycle and hold its ack high correspondingly.
REQ-023 Target SHALL be, in priority order: estop_req -> 0 (src 11); both valid -> min(sign,drv), src 01 on tie or sign smaller, else 10; sign only -> sign (01); driver only -> drv (10); else DEFAULT_LIMIT (00).
REQ-024 Target SHALL be computed combinationally from estop_req and the stored source registers; active_src SHALL register the target source every cycle.
REQ-025 The FSM SHALL have two states, HOLD and RAMP.
REQ-026 In any state, target < speed_limit SHALL load speed_limit=target on the next edge, enter or stay in HOLD, and clear the prescaler (decreases are never rate-limited).
REQ-027 In HOLD, target > speed_limit SHALL enter RAMP with the prescaler cleared; speed_limit unchanged that edge.
REQ-028 In RAMP, the prescaler SHALL count 0..RAMP_DIV-1; at terminal count speed_limit SHALL increase by min(RAMP_STEP, target-speed_limit), using 9-bit arithmetic, never overshooting or wrapping past 255.
REQ-029 When speed_limit equals target in RAMP, the FSM SHALL return to HOLD on the next edge.
REQ-030 An upward change of target during RAMP SHALL continue the ramp without clearing the prescaler.
REQ-031 Latency: a source captured at edge N SHALL affect speed_limit no earlier than edge N+1; estop_req sampled high at edge N SHALL produce speed_limit=0 at edge N.

Reset
REQ-032 rst_n=0 SHALL immediately force speed_limit=DEFAULT_LIMIT, active_src=00, ramping=0, sign_ack=drv_ack=0, state HOLD, prescaler 0, sign_valid=drv_valid=0.
REQ-033 Reset asserted mid-ramp SHALL abandon the ramp; after release the block SHALL resume from the reset values.

Verification
REQ-034 Sign down: after reset, sign_req with sign_limit=40 at edge N -> sign_ack=1 after edge N, speed_limit=40 and active_src=01 at edge N+1, ramping=0.
REQ-035 Ramp up: from 40, sign_clear -> target 60, ramping=1, speed_limit steps 42,44,...,60 every 4 cycles (40 cycles total), then ramping=0 and speed_limit holds 60.
REQ-036 Estop mid-ramp: at speed_limit=50 ramping, estop_req=1 -> speed_limit=0, active_src=11, ramping=0 on that edge; release -> ramp 0->target in steps of 2.
REQ-037 Arbitration: sign 50 and driver 45 valid -> speed_limit=45, active_src=10; driver then writes 0 -> target 50, ramp 45->47->49->50.
REQ-038 No overshoot/saturation: speed_limit=60, driver only 61 -> single tick to 61; driver 255 from 254 -> 255, no wrap.
REQ-039 Async reset: assert rst_n=0 between clock edges mid-ramp -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/speed_limit_arbiter.sv
// -----------------------------------------------------------------------------
// speed_limit_arbiter
//
// Chooses a speed limit from an emergency stop, a stored road-sign limit, a
// stored driver setpoint and a default. It then drives a rate-limited version
// of that choice to the car control unit. Decreases take effect on the next
// edge. Increases are ramped by at most RAMP_STEP every RAMP_DIV clock cycles.
//
// Parameters
//   DEFAULT_LIMIT  limit used when no source is active
//   RAMP_STEP      maximum increase per ramp tick
//   RAMP_DIV       clock cycles per ramp tick (1..255)
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   estop_req    in   level; emergency stop, forces the limit to 0
//   sign_req     in   road-sign update strobe (captures sign_limit)
//   sign_limit   in   road-sign limit, km/h
//   sign_clear   in   invalidates the stored sign limit (sign_req wins)
//   drv_req      in   driver setpoint update strobe (captures drv_limit)
//   drv_limit    in   driver setpoint, km/h; 0 means "no driver limit"
//   sign_ack     out  sign update accepted (cycle after capture)
//   drv_ack      out  driver update accepted (cycle after capture)
//   speed_limit  out  arbitrated, rate-limited limit
//   active_src   out  00 default, 01 sign, 10 driver, 11 estop
//   ramping      out  high while ramping up toward the target
// -----------------------------------------------------------------------------
module speed_limit_arbiter #(
  parameter logic [7:0] DEFAULT_LIMIT = 8'd60,
  parameter logic [7:0] RAMP_STEP     = 8'd2,
  parameter logic [7:0] RAMP_DIV      = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       estop_req,
  input  logic       sign_req,
  input  logic [7:0] sign_limit,
  input  logic       sign_clear,
  input  logic       drv_req,
  input  logic [7:0] drv_limit,
  output logic       sign_ack,
  output logic       drv_ack,
  output logic [7:0] speed_limit,
  output logic [1:0] active_src,
  output logic       ramping
);

  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [1:0] SRC_DEFAULT = 2'b00;
  localparam logic [1:0] SRC_SIGN    = 2'b01;
  localparam logic [1:0] SRC_DRV     = 2'b10;
  localparam logic [1:0] SRC_ESTOP   = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] speed_q, speed_d;
  logic [1:0] src_q, src_d;
  logic [7:0] sign_lim_q, sign_lim_d;
  logic       sign_valid_q, sign_valid_d;
  logic [7:0] drv_lim_q, drv_lim_d;
  logic       drv_valid_q, drv_valid_d;
  logic       sign_ack_q, sign_ack_d;
  logic       drv_ack_q, drv_ack_d;

  logic [7:0] target;
  logic [1:0] target_src;
  logic [8:0] ramp_sum;

  // Target selection. It uses the stored source registers, so a freshly
  // captured value affects the limit one edge later. estop_req is taken
  // straight from the input, so it pulls the limit to 0 on the edge that
  // samples it.
  always_comb begin
    target     = DEFAULT_LIMIT;
    target_src = SRC_DEFAULT;
    if (estop_req) begin
      target     = 8'd0;
      target_src = SRC_ESTOP;
    end else if (sign_valid_q && drv_valid_q) begin
      if (sign_lim_q <= drv_lim_q) begin
        target     = sign_lim_q;
        target_src = SRC_SIGN;
      end else begin
        target     = drv_lim_q;
        target_src = SRC_DRV;
      end
    end else if (sign_valid_q) begin
      target     = sign_lim_q;
      target_src = SRC_SIGN;
    end else if (drv_valid_q) begin
      target     = drv_lim_q;
      target_src = SRC_DRV;
    end
  end

  // Source capture and acknowledge.
  always_comb begin
    sign_lim_d   = sign_lim_q;
    sign_valid_d = sign_valid_q;
    drv_lim_d    = drv_lim_q;
    drv_valid_d  = drv_valid_q;
    sign_ack_d   = sign_req;
    drv_ack_d    = drv_req;
    src_d        = target_src;

    if (sign_req) begin
      sign_lim_d   = sign_limit;
      sign_valid_d = 1'b1;
    end else if (sign_clear) begin
      sign_valid_d = 1'b0;
    end

    if (drv_req) begin
      drv_lim_d   = drv_limit;
      drv_valid_d = (drv_limit != 8'd0);
    end
  end

  // Rate limiter. The step is computed in 9 bits so the sum can be compared
  // with the target before truncation. This keeps the limit from
  // overshooting the target and from wrapping past 255.
  assign ramp_sum = {1'b0, speed_q} + {1'b0, RAMP_STEP};

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    speed_d = speed_q;

    if (target < speed_q) begin
      // Decreases are applied at once from either state.
      speed_d = target;
      state_d = HOLD;
      presc_d = 8'd0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (target > speed_q) begin
            state_d = RAMP;
            presc_d = 8'd0;
          end
        end
        RAMP: begin
          if (target == speed_q) begin
            state_d = HOLD;
            presc_d = 8'd0;
          end else if (presc_q >= RAMP_DIV - 8'd1) begin
            presc_d = 8'd0;
            speed_d = (ramp_sum >= {1'b0, target}) ? target : ramp_sum[7:0];
          end else begin
            // A target that rises mid-ramp keeps the prescaler phase.
            presc_d = presc_q + 8'd1;
          end
        end
        default: begin
          state_d = HOLD;
          presc_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      presc_q      <= 8'd0;
      speed_q      <= DEFAULT_LIMIT;
      src_q        <= SRC_DEFAULT;
      sign_lim_q   <= 8'd0;
      sign_valid_q <= 1'b0;
      drv_lim_q    <= 8'd0;
      drv_valid_q  <= 1'b0;
      sign_ack_q   <= 1'b0;
      drv_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      speed_q      <= speed_d;
      src_q        <= src_d;
      sign_lim_q   <= sign_lim_d;
      sign_valid_q <= sign_valid_d;
      drv_lim_q    <= drv_lim_d;
      drv_valid_q  <= drv_valid_d;
      sign_ack_q   <= sign_ack_d;
      drv_ack_q    <= drv_ack_d;
    end
  end

  assign speed_limit = speed_q;
  assign active_src  = src_q;
  assign ramping     = (state_q == RAMP);
  assign sign_ack    = sign_ack_q;
  assign drv_ack     = drv_ack_q;

endmodule
